// File: rtl/reg_share_arb.sv
// rtl/reg_share_arb.sv - round-robin arbiter granting N requesters write access to one shared register
module reg_share_arb #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       din,
    input  logic                 clr,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         ack,
    output logic [W-1:0]         dout,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy
);
    localparam int OW = $clog2(N);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        WRITE,
        RECOVER,
        CLEAR
    } state_t;

    state_t        state;
    logic [OW-1:0] ptr;
    logic          pend_clr;
    logic [OW-1:0] win;
    logic [OW-1:0] nxt_ptr;
    logic [N-1:0]  win_onehot;

    // First requester found scanning upward from ptr, wrapping at N.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx = (int'(ptr) + i) % N;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    assign win_onehot = {{(N-1){1'b0}}, 1'b1} << win;
    assign nxt_ptr    = (owner == OW'(N-1)) ? '0 : owner + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            gnt      <= '0;
            ack      <= '0;
            dout     <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
            pend_clr <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack <= '0;
                    if (clr || pend_clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end else if (|req) begin
                        state <= GRANT;
                        gnt   <= win_onehot;
                        owner <= win;
                        busy  <= 1'b1;
                    end
                end
                GRANT: begin
                    ptr <= nxt_ptr;
                    if (clr)
                        pend_clr <= 1'b1;
                    if (req[owner]) begin
                        state <= WRITE;
                    end else begin
                        // Requester withdrew before the write: abandon silently.
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (clr)
                        pend_clr <= 1'b1;
                    dout  <= din[int'(owner)*W +: W];
                    gnt   <= '0;
                    ack   <= gnt;
                    state <= RECOVER;
                end
                RECOVER: begin
                    if (clr)
                        pend_clr <= 1'b1;
                    ack   <= '0;
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                CLEAR: begin
                    dout     <= '0;
                    pend_clr <= 1'b0;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                    ack   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reg_share_arb.sv
// tb/tb_reg_share_arb.sv - directed self-checking bench for reg_share_arb
module tb_reg_share_arb;
    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] din;
    logic        clr;
    logic [3:0]  gnt;
    logic [3:0]  ack;
    logic [7:0]  dout;
    logic [1:0]  owner;
    logic        busy;

    int checks;
    int errors;

    reg_share_arb #(.N(4), .W(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .din   (din),
        .clr   (clr),
        .gnt   (gnt),
        .ack   (ack),
        .dout  (dout),
        .owner (owner),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b0;
        req = '0;
        clr = 1'b0;
        din = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || dout !== 8'h00 || owner !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b ack=%b dout=%h owner=%0d busy=%b, expected all zero", gnt, ack, dout, owner, busy);
        end
    endtask

    task automatic test_single();
        din = 32'h00A5_0000;
        req = 4'b0100;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL single_grant1: gnt=%b owner=%0d busy=%b, expected 0100 2 1", gnt, owner, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0100 || ack !== 4'b0000) begin
            errors++;
            $display("FAIL single_grant2: gnt=%b ack=%b, expected 0100 0000", gnt, ack);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'hA5 || ack !== 4'b0100 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL single_write: dout=%h ack=%b gnt=%b, expected a5 0100 0000", dout, ack, gnt);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 4'b0000 || dout !== 8'hA5) begin
            errors++;
            $display("FAIL single_idle: busy=%b ack=%b dout=%h, expected 0 0000 a5", busy, ack, dout);
        end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_order [5];
        logic [7:0] exp_data  [5];
        exp_order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        exp_data  = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
        do_reset();
        din = 32'h1312_1110;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            @(negedge clk);
            checks++;
            if (owner !== exp_order[g] || gnt !== (4'b0001 << exp_order[g])) begin
                errors++;
                $display("FAIL fair_grant%0d: owner=%0d gnt=%b, expected owner %0d", g, owner, gnt, exp_order[g]);
            end
            @(negedge clk);
            @(negedge clk);
            checks++;
            if (dout !== exp_data[g] || ack !== (4'b0001 << exp_order[g])) begin
                errors++;
                $display("FAIL fair_write%0d: dout=%h ack=%b, expected %h", g, dout, ack, exp_data[g]);
            end
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || gnt !== 4'b0000 || ack !== 4'b0000) begin
                errors++;
                $display("FAIL fair_idle%0d: busy=%b gnt=%b ack=%b, expected 0 0000 0000", g, busy, gnt, ack);
            end
        end
        req = 4'b0000;
    endtask

    task automatic test_abandon();
        din = 32'h0000_7755;
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL abandon_grant: gnt=%b owner=%0d, expected 0010 1", gnt, owner);
        end
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || busy !== 1'b0 || dout !== 8'h10) begin
            errors++;
            $display("FAIL abandon_drop: gnt=%b ack=%b busy=%b dout=%h, expected 0000 0000 0 10", gnt, ack, busy, dout);
        end
        req = 4'b0011;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL abandon_wrap: gnt=%b owner=%0d, expected 0001 0", gnt, owner);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (dout !== 8'h55 || ack !== 4'b0001) begin
            errors++;
            $display("FAIL abandon_next_write: dout=%h ack=%b, expected 55 0001", dout, ack);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_simul_clear();
        clr = 1'b1;
        req = 4'b0001;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0000 || dout !== 8'h55) begin
            errors++;
            $display("FAIL simclr_clear: busy=%b gnt=%b dout=%h, expected 1 0000 55", busy, gnt, dout);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h00 || gnt !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL simclr_done: dout=%h gnt=%b busy=%b, expected 00 0000 0", dout, gnt, busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001 || owner !== 2'd0) begin
            errors++;
            $display("FAIL simclr_grant: gnt=%b owner=%0d, expected 0001 0", gnt, owner);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_clear_collision();
        din = 32'h0000_003C;
        req = 4'b0001;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL coll_grant: gnt=%b, expected 0001", gnt);
        end
        @(negedge clk);
        clr = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (dout !== 8'h3C || ack !== 4'b0001) begin
            errors++;
            $display("FAIL coll_write: dout=%h ack=%b, expected 3c 0001", dout, ack);
        end
        req = 4'b0010;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || dout !== 8'h3C || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL coll_recover_idle: busy=%b dout=%h gnt=%b, expected 0 3c 0000", busy, dout, gnt);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL coll_clear_first: busy=%b gnt=%b, expected 1 0000", busy, gnt);
        end
        @(negedge clk);
        checks++;
        if (dout !== 8'h00 || gnt !== 4'b0000) begin
            errors++;
            $display("FAIL coll_cleared: dout=%h gnt=%b, expected 00 0000", dout, gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1) begin
            errors++;
            $display("FAIL coll_next_grant: gnt=%b owner=%0d, expected 0010 1", gnt, owner);
        end
        req = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        din = 32'h0000_9900;
        req = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010 || owner !== 2'd1 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_inwrite: gnt=%b owner=%0d busy=%b, expected 0010 1 1", gnt, owner, busy);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0000 || ack !== 4'b0000 || dout !== 8'h00 || owner !== 2'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: gnt=%b ack=%b dout=%h owner=%0d busy=%b, expected all zero", gnt, ack, dout, owner, busy);
        end
        @(negedge clk);
        req = 4'b0000;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ack !== 4'b0000 || dout !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_after: ack=%b dout=%h busy=%b, expected 0000 00 0", ack, dout, busy);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        req = '0;
        din = '0;
        clr = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_abandon();
        test_simul_clear();
        test_clear_collision();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter N, default 4, number of requesters (N >= 2).
REQ-002 Parameter W, default 8, width of the shared data register.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst == 0 resets).
REQ-005 req  input  N  per-requester write request, level-held until ack or abandon.
REQ-006 din  input  N*W  per-requester write data, slice i = din[i*W +: W].
REQ-007 clr  input  1  synchronous clear request for the shared register, 1-cycle pulse or level.
REQ-008 gnt  output  N  one-hot grant, registered.
REQ-009 ack  output  N  one-hot write-done pulse, registered.
REQ-010 dout  output  W  shared register contents, registered.
REQ-011 owner  output  $clog2(N)  index of current/last granted requester, registered.
REQ-012 busy  output  1  high whenever FSM is not IDLE, registered.

Function
REQ-013 FSM states SHALL be IDLE, GRANT, WRITE, RECOVER, CLEAR; encoding is implementation choice.
REQ-014 IDLE, clr or pending-clear set: next state CLEAR (clear beats any req).
REQ-015 IDLE, no clear, req != 0: select winner round-robin, search starting at ptr; next state GRANT, gnt[winner]=1, owner=winner.
REQ-016 IDLE, no clear, req == 0: stay IDLE, gnt=0, dout held.
REQ-017 GRANT (exactly 1 cycle): gnt held; req[owner]==1 -> WRITE; req[owner]==0 -> IDLE with no write, no ack (abandon).
REQ-018 WRITE (1 cycle): gnt held; on exit edge dout <= din slice of owner, gnt <= 0, ack[owner] <= 1; next RECOVER.
REQ-019 RECOVER (1 cycle): ack high only this cycle; gnt=0; next IDLE.
REQ-020 CLEAR (1 cycle): on exit edge dout <= 0, pending-clear <= 0; no gnt, no ack; next IDLE.
REQ-021 Round-robin pointer ptr SHALL become (owner+1) mod N when leaving GRANT, whether written or abandoned.
REQ-022 clr seen in GRANT, WRITE or RECOVER SHALL set pending-clear; in-flight write completes first, then CLEAR runs before the next grant.
REQ-023 At most one gnt bit and one ack bit high in any cycle; gnt and ack never high together.
REQ-024 Latency: req sampled in IDLE at edge k -> gnt high from edge k+1 -> dout updated and ack high at edge k+3 -> IDLE at edge k+4; max one write per 4 cycles.
REQ-025 din and req of non-owners SHALL be ignored while busy; changes to din[owner] are taken as sampled in WRITE.
REQ-026 Requester that keeps req high after ack SHALL be re-arbitrated as a new request, subject to ptr.
REQ-027 busy SHALL be 0 in IDLE and 1 in every other state.

Reset
REQ-028 rst low SHALL immediately force state IDLE, gnt=0, ack=0, dout=0, owner=0, busy=0, ptr=0, pending-clear=0, regardless of clk.
REQ-029 rst low mid-transaction SHALL abort it: no ack issued, dout not loaded with that data.
REQ-030 First arbitration after rst release SHALL give requester 0 highest priority.

Verification
REQ-031 Single: rst release, req=4'b0100, din slice2=8'hA5 -> gnt=4'b0100 two cycles, then dout=8'hA5, ack=4'b0100 one cycle, busy low after.
REQ-032 Fairness: req=4'b1111 held, slices 8'h10/8'h11/8'h12/8'h13 -> grants in order 0,1,2,3,0; dout sequence 10,11,12,13,10.
REQ-033 Abandon: req=4'b0010 dropped in GRANT cycle -> no ack, dout unchanged; next req=4'b0011 grants 0 first only if ptr==0, else per ptr (ptr=2 -> grants 0 after wrap).
REQ-034 Clear collision: clr pulse during WRITE of 8'h3C -> dout=8'h3C with ack, then CLEAR cycle -> dout=8'h00 before next gnt.
REQ-035 Simultaneous clr and req=4'b0001 in IDLE -> CLEAR first (dout=0), then grant to requester 0.
REQ-036 Async reset: rst low in WRITE with owner=1 -> outputs zero immediately, no ack[1], dout=0 after release.
